// File: rtl/bcd_display_scan.sv
// Multiplexed 11-digit BCD seven-segment scanner with a load-captured shadow register.
// Optional leading-zero blanking is enabled by defining BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic [3:0]  BCD0,
    input  logic [3:0]  BCD1,
    input  logic [3:0]  BCD2,
    input  logic [3:0]  BCD3,
    input  logic [3:0]  BCD4,
    input  logic [3:0]  BCD5,
    input  logic [3:0]  BCD6,
    input  logic [3:0]  BCD7,
    input  logic [3:0]  BCD8,
    input  logic [3:0]  BCD9,
    input  logic [3:0]  BCD10,
    output logic [10:0] an,
    output logic [6:0]  seg,
    output logic        valid
);

    localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]     LAST_IDX   = 4'd10;

    logic [PW-1:0]     presc;
    logic [3:0]        digit_idx;
    logic [10:0][3:0]  shadow;
    logic              presc_tc;
    logic [3:0]        cur_digit;
    logic [6:0]        cur_seg;
    logic [10:0]       cur_an;
    logic              blank_slot;
    logic              zero_run;

    assign presc_tc = (presc == PRESC_LAST);
    assign cur_an   = ~(11'd1 << digit_idx);

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i <= 10; i++) begin
            if (digit_idx == 4'(i)) cur_digit = shadow[i];
        end
    end

    // Walk from the top digit down; a slot is blank when it and everything above it is zero.
    always_comb begin
        blank_slot = 1'b0;
        zero_run   = 1'b1;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        for (int i = 10; i >= 1; i--) begin
            zero_run = zero_run & (shadow[i] == 4'd0);
            if (digit_idx == 4'(i) && zero_run) blank_slot = 1'b1;
        end
`endif
    end

    always_comb begin
        case (cur_digit)
            4'd0:    cur_seg = 7'h40;
            4'd1:    cur_seg = 7'h79;
            4'd2:    cur_seg = 7'h24;
            4'd3:    cur_seg = 7'h30;
            4'd4:    cur_seg = 7'h19;
            4'd5:    cur_seg = 7'h12;
            4'd6:    cur_seg = 7'h02;
            4'd7:    cur_seg = 7'h78;
            4'd8:    cur_seg = 7'h00;
            4'd9:    cur_seg = 7'h10;
            default: cur_seg = 7'h3F;
        endcase
    end

    // an/seg are driven from the index and shadow as they stood before this edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc     <= '0;
            digit_idx <= 4'd0;
            shadow    <= '0;
            valid     <= 1'b0;
            an        <= 11'h7FF;
            seg       <= 7'h7F;
        end else begin
            if (presc_tc) begin
                presc     <= '0;
                digit_idx <= (digit_idx == LAST_IDX) ? 4'd0 : digit_idx + 4'd1;
            end else begin
                presc     <= presc + 1'b1;
            end

            if (load) begin
                shadow <= {BCD10, BCD9, BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
                valid  <= 1'b1;
            end

            if (!valid || blank_slot) begin
                an  <= 11'h7FF;
                seg <= 7'h7F;
            end else begin
                an  <= cur_an;
                seg <= cur_seg;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan at REFRESH_DIV=4: vector table plus scan/reset corner sequences.
module tb_bcd_display_scan;

    localparam int DIV = 4;

    logic             Clk;
    logic             Reset;
    logic             load;
    logic [10:0][3:0] bcd;
    logic [10:0]      an;
    logic [6:0]       seg;
    logic             valid;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_display_scan #(.REFRESH_DIV(DIV)) dut (
        .Clk(Clk), .Reset(Reset), .load(load),
        .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]),
        .BCD4(bcd[4]), .BCD5(bcd[5]), .BCD6(bcd[6]), .BCD7(bcd[7]),
        .BCD8(bcd[8]), .BCD9(bcd[9]), .BCD10(bcd[10]),
        .an(an), .seg(seg), .valid(valid)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Digit patterns, nibble 10 first
    localparam logic [43:0] P_COUNT = 44'h09876543210;
    localparam logic [43:0] P_MIX   = 44'hFEDBA865421;
    localparam logic [43:0] P_C5    = 44'h09876C43210;
    localparam logic [43:0] P_42    = 44'h00000000042;
    localparam logic [43:0] P_NEW3  = 44'h09876547210;

    typedef struct {
        logic [43:0] digits;
        int          slot;
        logic [10:0] exp_an;
        logic [6:0]  exp_seg;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [43:0] d, input int s, input logic [10:0] a, input logic [6:0] g);
        vec_t v;
        v.digits = d; v.slot = s; v.exp_an = a; v.exp_seg = g;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pulse Reset between edges, then load on the first edge after release.
    task automatic reset_and_load(input logic [43:0] pat);
        @(negedge Clk);
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        load  = 1'b1;
        bcd   = pat;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        load  = 1'b0;
        bcd   = '0;

        // Table: output after edge 4*slot+2 shows index slot%11.
        add_vec(P_COUNT, 0,  11'h7FE, 7'h40);
        add_vec(P_COUNT, 1,  11'h7FD, 7'h79);
        add_vec(P_COUNT, 3,  11'h7F7, 7'h30);
        add_vec(P_COUNT, 7,  11'h77F, 7'h78);
        add_vec(P_COUNT, 9,  11'h5FF, 7'h10);
        add_vec(P_COUNT, 11, 11'h7FE, 7'h40);
        add_vec(P_C5,    5,  11'h7DF, 7'h3F);
        add_vec(P_MIX,   0,  11'h7FE, 7'h79);
        add_vec(P_MIX,   1,  11'h7FD, 7'h24);
        add_vec(P_MIX,   2,  11'h7FB, 7'h19);
        add_vec(P_MIX,   3,  11'h7F7, 7'h12);
        add_vec(P_MIX,   4,  11'h7EF, 7'h02);
        add_vec(P_MIX,   5,  11'h7DF, 7'h00);
        add_vec(P_MIX,   6,  11'h7BF, 7'h3F);
        add_vec(P_MIX,   8,  11'h6FF, 7'h3F);
        add_vec(P_MIX,   10, 11'h3FF, 7'h3F);
        add_vec(P_42,    0,  11'h7FE, 7'h24);
        add_vec(P_42,    1,  11'h7FD, 7'h19);
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        add_vec(P_COUNT, 10, 11'h7FF, 7'h7F);
        add_vec(P_42,    2,  11'h7FF, 7'h7F);
        add_vec(P_42,    10, 11'h7FF, 7'h7F);
`else
        add_vec(P_COUNT, 10, 11'h3FF, 7'h40);
        add_vec(P_42,    2,  11'h7FB, 7'h40);
        add_vec(P_42,    10, 11'h3FF, 7'h40);
`endif

        // Reset state while Reset held across edges
        tick();
        tick();
        check("rst_an",    32'(an),             32'h7FF);
        check("rst_seg",   32'(seg),            32'h7F);
        check("rst_valid", 32'(valid),          32'h0);
        check("rst_idx",   32'(dut.digit_idx),  32'h0);

        // No load yet: dark for 100 cycles, index still scanning
        @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            check($sformatf("dark_an_c%0d", c), 32'(an), 32'h7FF);
        end
        check("dark_seg",   32'(seg),            32'h7F);
        check("dark_idx",   32'(dut.digit_idx),  32'd3);
        check("dark_valid", 32'(valid),          32'h0);

        // valid rises the cycle after load; display lags one more cycle
        reset_and_load(P_COUNT);
        check("load_valid", 32'(valid), 32'h1);
        check("load_an",    32'(an),    32'h7FF);
        tick();
        check("first_an",   32'(an),    32'h7FE);
        check("first_seg",  32'(seg),   32'h40);

        // Table-driven vectors
        foreach (vecs[i]) begin
            reset_and_load(vecs[i].digits);
            repeat (4 * vecs[i].slot + 1) tick();
            check($sformatf("vec%0d_an", i),    32'(an),    32'(vecs[i].exp_an));
            check($sformatf("vec%0d_seg", i),   32'(seg),   32'(vecs[i].exp_seg));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'h1);
        end

        // Load on the terminal-count edge as index goes 2->3 (edge 12)
        reset_and_load(P_COUNT);
        repeat (10) tick();
        load = 1'b1;
        bcd  = P_NEW3;
        tick();
        load = 1'b0;
        check("tc_old_seg", 32'(seg), 32'h24);
        check("tc_old_an",  32'(an),  32'h7FB);
        tick();
        check("tc_new_seg", 32'(seg),           32'h78);
        check("tc_new_an",  32'(an),            32'h7F7);
        check("tc_idx",     32'(dut.digit_idx), 32'd3);
        // Identical reload while valid: nothing visible changes, index undisturbed
        load = 1'b1;
        tick();
        load = 1'b0;
        check("same_seg",   32'(seg),           32'h78);
        check("same_an",    32'(an),            32'h7F7);
        check("same_presc", 32'(dut.presc),     32'd2);
        check("same_idx",   32'(dut.digit_idx), 32'd3);

        // Async reset mid-scan at index 6, then restart at digit 0
        reset_and_load(P_COUNT);
        repeat (24) tick();
        check("mid_seg", 32'(seg), 32'h02);
        check("mid_an",  32'(an),  32'h7BF);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("async_an",    32'(an),            32'h7FF);
        check("async_seg",   32'(seg),           32'h7F);
        check("async_valid", 32'(valid),         32'h0);
        check("async_idx",   32'(dut.digit_idx), 32'h0);
        #1;
        Reset = 1'b0;
        load  = 1'b1;
        bcd   = P_MIX;
        tick();
        load  = 1'b0;
        check("restart_idx1", 32'(dut.digit_idx), 32'd0);
        tick();
        check("restart_an",   32'(an),            32'h7FE);
        check("restart_seg",  32'(seg),           32'h79);
        tick();
        check("restart_idx3", 32'(dut.digit_idx), 32'd0);
        tick();
        check("restart_idx4", 32'(dut.digit_idx), 32'd1);

        // Load coinciding with Reset is ignored
        @(negedge Clk);
        Reset = 1'b1;
        load  = 1'b1;
        bcd   = P_MIX;
        tick();
        load  = 1'b0;
        #2;
        Reset = 1'b0;
        tick();
        tick();
        check("rstload_valid", 32'(valid),       32'h0);
        check("rstload_an",    32'(an),          32'h7FF);
        check("rstload_shadow", 32'(dut.shadow[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the number of Clk cycles each digit stays selected; legal range is 2 or more.
REQ-002 The block SHALL have one clock, Clk; reset is asynchronous and active-high, port Reset.
REQ-003 Port Clk SHALL be an input, 1 bit wide: system clock, rising-edge active.
REQ-004 Port Reset SHALL be an input, 1 bit wide: asynchronous active-high reset.
REQ-005 Port load SHALL be an input, 1 bit wide: single-cycle strobe that captures BCD0..BCD10 when conversion completes.
REQ-006 Ports BCD0..BCD10 SHALL each be an input, 4 bits wide: BCD0 is the least significant decimal digit.
REQ-007 Port an SHALL be an output, 11 bits wide: one-hot active-low digit enables; an[i] selects digit i.
REQ-008 Port seg SHALL be an output, 7 bits wide: active-low segments {g,f,e,d,c,b,a}.
REQ-009 Port valid SHALL be an output, 1 bit wide: high once at least one load has been captured since reset.

Function
REQ-010 The block SHALL hold an 11x4-bit shadow register and SHALL capture all 11 digits on any rising Clk edge where load=1.
REQ-011 The block SHALL run a prescaler that counts 0..REFRESH_DIV-1 and wraps; its width SHALL be clog2(REFRESH_DIV).
REQ-012 On the prescaler terminal count, the block SHALL advance the digit index 0,1,...,10, and SHALL wrap from 10 to 0.
REQ-013 an and seg SHALL be registered, reflecting the digit index and shadow register sampled one cycle earlier (latency 1 cycle).
REQ-014 While valid=0, an SHALL be 11'h7FF and seg SHALL be 7'h7F; the prescaler and index SHALL still run.
REQ-015 While valid=1, an SHALL equal ~(1<<index).
REQ-016 Segment encoding (seg) for digits 0-9 SHALL be: 40,79,24,30,19,12,02,78,00,10 (hex).
REQ-017 Digit values 10-15 SHALL display a dash, seg=7'h3F.
REQ-018 When load coincides with terminal count, both actions SHALL take effect on the same edge; the newly selected digit SHALL show the new shadow value.
REQ-019 A load while valid=1 SHALL replace the shadow register without disturbing the index or prescaler.
REQ-020 A load with an unchanged value SHALL produce no visible change.

Reset
REQ-021 Reset=1 SHALL immediately force prescaler=0, index=0, shadow=all zero, valid=0, an=11'h7FF, and seg=7'h7F, regardless of Clk.
REQ-022 Reset asserted mid-scan SHALL abandon the current digit; after release, scanning SHALL restart at digit 0 with a full REFRESH_DIV period.
REQ-023 load asserted in the same cycle as Reset SHALL be ignored.

Configuration
REQ-024 With macro BCD_DISPLAY_LEADING_ZERO_BLANK_EN defined, for index i>0 where shadow digit i and all higher digits are 0, the block SHALL drive an=11'h7FF and seg=7'h7F for that slot.
REQ-025 Digit 0 SHALL never be blanked by the leading-zero rule, and scan timing SHALL be unaffected by blanking.
REQ-026 With BCD_DISPLAY_LEADING_ZERO_BLANK_EN undefined, all 11 digits SHALL be displayed, including leading zeros.

Verification
REQ-027 Scenario (REFRESH_DIV=4): after reset, load digits 0..9,0 (BCD0=0 ... BCD10=0) -> valid=1 next cycle; an steps 7FE,7FD,... every 4 cycles; seg for index 3 is 30; after index 10, index wraps to 0.
REQ-028 Scenario: load with BCD5=4'hC, then wait for index 5 -> seg=3F and an=7DF.
REQ-029 Scenario (macro defined): load value 42 (BCD1=4, BCD0=2, rest 0) -> index 0 gives seg=24, index 1 gives seg=19, indices 2-10 give an=7FF; (macro undefined) index 2 gives an=7FB and seg=40.
REQ-030 Scenario: assert Reset asynchronously between Clk edges while index=6 -> an=7FF, seg=7F, and valid=0 immediately; after release and a new load, the first selected digit is 0 after REFRESH_DIV cycles.
REQ-031 Scenario: assert load on the terminal-count edge while index goes 2->3, with new BCD3=7 -> the next registered seg is 78, not the old digit.
REQ-032 Scenario: before any load -> an=7FF for 100 cycles, and the index still advances (checked via internal probe).
